// File: rtl/gate_reduce_pkg.sv
// Shared encodings and helpers for gate_reduce_unit: operation codes, base
// reduction ops and FSM states.
package gate_reduce_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    BASE_AND = 2'd0,
    BASE_OR  = 2'd1,
    BASE_XOR = 2'd2
  } base_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Illegal codes 6/7 fall through to AND; the frame is flagged separately.
  function automatic base_e base_of(input logic [2:0] op);
    case (op)
      OP_OR, OP_NOR:   return BASE_OR;
      OP_XOR, OP_XNOR: return BASE_XOR;
      default:         return BASE_AND;
    endcase
  endfunction

  function automatic logic op_inverts(input logic [2:0] op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

  function automatic logic op_illegal(input logic [2:0] op);
    return op > OP_XNOR;
  endfunction

endpackage

// File: rtl/gate_reduce_core.sv
// Combinational bitwise reduction of NUM_IN operands of WIDTH bits with one
// base operation (AND/OR/XOR).
module gate_reduce_core
  import gate_reduce_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 4
) (
  input  base_e                    base,
  input  logic [NUM_IN*WIDTH-1:0]  data,
  output logic [WIDTH-1:0]         result
);

  always_comb begin
    result = data[WIDTH-1:0];
    for (int unsigned k = 1; k < NUM_IN; k++) begin
      case (base)
        BASE_OR:  result = result | data[k*WIDTH +: WIDTH];
        BASE_XOR: result = result ^ data[k*WIDTH +: WIDTH];
        default:  result = result & data[k*WIDTH +: WIDTH];
      endcase
    end
  end

endmodule

// File: rtl/gate_reduce_unit.sv
// Pipelined multi-operand gate: per-beat reduction (S1), frame fold (acc) and
// held output register. Optional frame counter under `GATE_STATS_EN.
module gate_reduce_unit
  import gate_reduce_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 4
`ifdef GATE_STATS_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN*WIDTH-1:0]  in_data,
  input  logic [2:0]               in_op,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero,
  output logic                     out_err
`ifdef GATE_STATS_EN
  , output logic [CNT_W-1:0]       frame_cnt
`endif
);

  state_e            state, state_nxt;
  logic [2:0]        frame_op;
  logic              run;

  logic [2:0]        eff_op;
  base_e             in_base;
  logic [WIDTH-1:0]  beat_red;
  logic              fire;

  logic              s1_valid, s1_last, s1_first, s1_inv, s1_err;
  base_e             s1_base;
  logic [WIDTH-1:0]  s1_data;
  logic              s1_can_advance, s1_adv, emit;

  logic [WIDTH-1:0]  acc, fold_comb, fold, result_val;

  // The frame op is taken from the opening beat; later beats reuse the latched copy.
  assign eff_op  = (state == ST_IDLE) ? in_op : frame_op;
  assign in_base = base_of(eff_op);

  gate_reduce_core #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_beat_core (
    .base   (in_base),
    .data   (in_data),
    .result (beat_red)
  );

  // Only a last beat needs the output register; non-last beats always drain into acc.
  assign s1_can_advance = !s1_last || !out_valid || out_ready;
  assign in_ready       = run && (!s1_valid || s1_can_advance);
  assign fire           = in_valid && in_ready;
  assign s1_adv         = s1_valid && s1_can_advance;
  assign emit           = s1_adv && s1_last;

  gate_reduce_core #(.WIDTH(WIDTH), .NUM_IN(2)) u_fold_core (
    .base   (s1_base),
    .data   ({acc, s1_data}),
    .result (fold_comb)
  );

  assign fold       = s1_first ? s1_data : fold_comb;
  assign result_val = s1_inv ? ~fold : fold;

  always_comb begin
    state_nxt = state;
    if (fire) begin
      case (state)
        ST_IDLE:  if (!in_last) state_nxt = ST_ACCUM;
        ST_ACCUM: if (in_last)  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      frame_op <= '0;
      run      <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      if (fire && state == ST_IDLE) frame_op <= in_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      s1_inv   <= 1'b0;
      s1_err   <= 1'b0;
      s1_base  <= BASE_AND;
      s1_data  <= '0;
    end else if (in_ready) begin
      s1_valid <= fire;
      if (fire) begin
        s1_last  <= in_last;
        s1_first <= (state == ST_IDLE);
        s1_inv   <= op_inverts(eff_op);
        s1_err   <= op_illegal(eff_op);
        s1_base  <= in_base;
        s1_data  <= beat_red;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (s1_adv && !s1_last) begin
      acc <= fold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b0;
      out_err   <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= result_val;
      out_zero  <= (result_val == '0);
      out_err   <= s1_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef GATE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (out_valid && out_ready && frame_cnt != '1) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_reduce_unit.sv
// Scoreboard bench for gate_reduce_unit (WIDTH=8, NUM_IN=4); frame_cnt checks
// are active when GATE_STATS_EN is defined (CNT_W=2).
module tb_gate_reduce_unit;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic           out_ready = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [2:0]     in_op = '0;
  logic           in_ready, out_valid, out_zero, out_err;
  logic [W-1:0]   out_data;
`ifdef GATE_STATS_EN
  logic [1:0]     frame_cnt;
`endif

  gate_reduce_unit #(
    .WIDTH  (W),
    .NUM_IN (N)
`ifdef GATE_STATS_EN
    , .CNT_W (2)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_err   (out_err)
`ifdef GATE_STATS_EN
    , .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       zero;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_res(input logic [7:0] d, input logic err);
    exp_t e;
    e.data = d;
    e.zero = (d == 8'h00);
    e.err  = err;
    q.push_back(e);
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] op, input logic last);
    int  n;
    logic rdy;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_last  = last;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat %0h not accepted in %0d cycles", d, n);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input logic rdy_exp);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_out_data", out_data, 0);
    chk("idle_out_zero", out_zero, 0);
    chk("idle_out_err", out_err, 0);
    chk("idle_in_ready", in_ready, rdy_exp);
`ifdef GATE_STATS_EN
    chk("idle_frame_cnt", frame_cnt, 0);
`endif
  endtask

  // Monitor: pops on each output handshake and checks held results stay put.
  initial begin
    exp_t       e;
    logic       held;
    logic [7:0] h_data;
    logic       h_zero, h_err;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (held) begin
          chk("hold_data", out_data, h_data);
          chk("hold_zero", out_zero, h_zero);
          chk("hold_err", out_err, h_err);
        end
        if (out_ready) begin
          held = 1'b0;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h, expected no result", out_data);
          end else begin
            e = q.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_zero", out_zero, e.zero);
            chk("out_err", out_err, e.err);
          end
        end else begin
          held   = 1'b1;
          h_data = out_data;
          h_zero = out_zero;
          h_err  = out_err;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] t6_data [4] = '{32'hFF3F1F0F, 32'h00000201, 32'h00000FFF, 32'h00000000};
  logic [2:0]  t6_op   [4] = '{3'd0, 3'd4, 3'd2, 3'd3};
  logic [7:0]  t6_exp  [4] = '{8'h0F, 8'hFC, 8'hF0, 8'hFF};
  logic [1:0]  t6_cnt  [4] = '{2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs(1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_release", in_ready, 1);

    // 1: single-beat AND
    expect_res(8'h30, 1'b0);
    send({8'hFF, 8'h3C, 8'hF0, 8'hFF}, 3'd0, 1'b1);
    wait_drain();

    // 2: 3-beat NAND, op on later beats ignored
    expect_res(8'hF0, 1'b0);
    send(32'hFFFFFFFF, 3'd3, 1'b0);
    send(32'hFFFFFF0F, 3'd1, 1'b0);
    send(32'hFFFF8FFF, 3'd3, 1'b1);
    wait_drain();

    // 3: illegal op, then a clean XOR frame
    expect_res(8'hAA, 1'b1);
    send(32'hAAAAAAAA, 3'd7, 1'b1);
    expect_res(8'h0F, 1'b0);
    send(32'h08040201, 3'd2, 1'b1);
    wait_drain();

    // 4: backpressure with two XNOR frames
    out_ready = 1'b0;
    expect_res(8'h00, 1'b0);
    send(32'h000000FF, 3'd5, 1'b1);
    expect_res(8'hFF, 1'b0);
    send(32'h00000000, 3'd5, 1'b1);
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready_still_low", in_ready, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_out_valid", out_valid, 1);
    chk("b2b_out_data", out_data, 8'hFF);
    wait_drain();

    // 5: reset mid OR frame
    send(32'h00000010, 3'd1, 1'b0);
    send(32'h00000100, 3'd1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs(1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs(1'b1);
    expect_res(8'h01, 1'b0);
    send(32'h00000100, 3'd1, 1'b1);
    wait_drain();
`ifdef GATE_STATS_EN
    chk("frame_cnt_1", frame_cnt, 1);
`endif

    // 6: further frames, counter saturates at 3 with CNT_W=2
    for (int i = 0; i < 4; i++) begin
      expect_res(t6_exp[i], 1'b0);
      send(t6_data[i], t6_op[i], 1'b1);
      wait_drain();
`ifdef GATE_STATS_EN
      chk("frame_cnt_seq", frame_cnt, t6_cnt[i]);
`endif
    end

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
